// File: rtl/cbb_sync_pkg.sv
// rtl/cbb_sync_pkg.sv - shared edge-mode encodings and counter-width helper
//
// Purpose : constants and helpers used by the multi-channel edge synchronizer.
// Contents: EDGE_* per-channel mode encodings, clog2() for counter widths.
package cbb_sync_pkg;

  // Per-channel detector mode, two bits per channel on i_edge_sel.
  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;
  localparam logic [1:0] EDGE_LEVEL = 2'b11;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cbb_multi_edge_synchronizer_if.sv
// rtl/cbb_multi_edge_synchronizer_if.sv - event-line bundle between source and synchronizer
//
// Purpose : groups the per-channel event inputs, controls and results.
// Signals : i_async    - asynchronous event/level lines, one per channel
//           i_edge_sel - two mode bits per channel ([2c+1:2c])
//           i_en       - global event enable
//           i_ovf_clr  - clears all sticky overflow bits
//           o_level    - filtered, synchronized level per channel
//           o_pulse    - stretched event pulse (delayed level in level mode)
//           o_ovf      - sticky overflow per channel
// Modports: master drives the inputs and observes results; slave is the synchronizer.
interface cbb_multi_edge_synchronizer_if #(
  parameter int P_CH_NUM = 4
) ();

  logic [P_CH_NUM-1:0]   i_async;
  logic [2*P_CH_NUM-1:0] i_edge_sel;
  logic                  i_en;
  logic                  i_ovf_clr;
  logic [P_CH_NUM-1:0]   o_level;
  logic [P_CH_NUM-1:0]   o_pulse;
  logic [P_CH_NUM-1:0]   o_ovf;

  modport master (
    output i_async,
    output i_edge_sel,
    output i_en,
    output i_ovf_clr,
    input  o_level,
    input  o_pulse,
    input  o_ovf
  );

  modport slave (
    input  i_async,
    input  i_edge_sel,
    input  i_en,
    input  i_ovf_clr,
    output o_level,
    output o_pulse,
    output o_ovf
  );

endinterface

// File: rtl/cbb_sync_chan.sv
// rtl/cbb_sync_chan.sv - one channel: synchronizer, glitch filter, edge detect, stretch, overflow
//
// Purpose : brings one asynchronous line into i_clk and turns accepted level
//           changes into a stretched, retriggerable pulse.
// Ports   : i_clk, i_rst (async, active high)
//           i_async    - raw asynchronous input
//           i_edge_sel - mode: rise / fall / both / level
//           i_en       - event enable (ignored in level mode)
//           i_ovf_clr  - clear sticky overflow (a same-cycle set wins)
//           o_level    - filtered level
//           o_pulse    - stretched event pulse, or level delayed one cycle
//           o_ovf      - sticky overflow
module cbb_sync_chan
  import cbb_sync_pkg::*;
#(
  parameter int P_SYNC_STAGE = 2,
  parameter int P_FILT_LEN   = 3,
  parameter int P_STRETCH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_async,
  input  logic [1:0] i_edge_sel,
  input  logic       i_en,
  input  logic       i_ovf_clr,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_ovf
);

  localparam int LP_CNT_W  = clog2(P_FILT_LEN + 1);
  localparam int LP_SCNT_W = clog2(P_STRETCH + 1);
  localparam logic [LP_CNT_W-1:0]  LP_CNT_LAST  = LP_CNT_W'(P_FILT_LEN - 1);
  localparam logic [LP_SCNT_W-1:0] LP_SCNT_LOAD = LP_SCNT_W'(P_STRETCH - 1);

  logic [P_SYNC_STAGE-1:0] r_sync;
  logic [LP_CNT_W-1:0]     r_cnt;
  logic                    r_level;
  logic                    r_level_d;
  logic [LP_SCNT_W-1:0]    r_scnt;
  logic                    r_pulse;
  logic                    r_ovf;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_evt_sel;
  logic w_level_mode;
  logic w_evt;
  logic w_ovf_set;

  // Synchronizer shift chain; the last stage is the only one the filter sees.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[P_SYNC_STAGE-2:0], i_async};
    end
  end

  assign w_sync = r_sync[P_SYNC_STAGE-1];

  // Glitch filter: the synchronized value must disagree with o_level for
  // P_FILT_LEN consecutive samples before o_level follows it. Any agreeing
  // sample in between restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_CNT_LAST) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The delayed copy runs in every mode so a mode or enable change never
  // sees a stale level and fakes an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign w_rise = r_level & ~r_level_d;
  assign w_fall = ~r_level & r_level_d;

  always_comb begin
    w_evt_sel = 1'b0;
    case (i_edge_sel)
      EDGE_RISE: w_evt_sel = w_rise;
      EDGE_FALL: w_evt_sel = w_fall;
      EDGE_BOTH: w_evt_sel = w_rise | w_fall;
      default:   w_evt_sel = 1'b0;
    endcase
  end

  assign w_level_mode = (i_edge_sel == EDGE_LEVEL);
  assign w_evt        = w_evt_sel & i_en & ~w_level_mode;

  // An event counts as overflow only while the pulse still has cycles left;
  // an event landing in the final cycle simply chains a new pulse.
  assign w_ovf_set = w_evt & r_pulse & (r_scnt != '0);

  // Stretcher. Level mode parks the counter at zero so a switch back to an
  // edge mode drops the pulse on the next cycle unless an event arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pulse <= 1'b0;
      r_scnt  <= '0;
    end else if (w_level_mode) begin
      r_pulse <= r_level;
      r_scnt  <= '0;
    end else if (w_evt) begin
      r_pulse <= 1'b1;
      r_scnt  <= LP_SCNT_LOAD;
    end else if (r_scnt != '0) begin
      r_pulse <= 1'b1;
      r_scnt  <= r_scnt - 1'b1;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  // Sticky overflow; set has priority over a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/cbb_multi_edge_synchronizer.sv
// rtl/cbb_multi_edge_synchronizer.sv - P_CH_NUM independent synchronizer/edge/stretch channels
//
// Purpose : entry point for external or foreign-domain event lines into i_clk.
// Ports   : i_clk - single clock, all logic in this domain
//           i_rst - asynchronous active-high reset
//           bus   - slave side of cbb_multi_edge_synchronizer_if (inputs
//                   i_async/i_edge_sel/i_en/i_ovf_clr, outputs o_level/o_pulse/o_ovf)
module cbb_multi_edge_synchronizer
  import cbb_sync_pkg::*;
#(
  parameter int P_CH_NUM     = 4,
  parameter int P_SYNC_STAGE = 2,
  parameter int P_FILT_LEN   = 3,
  parameter int P_STRETCH    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  cbb_multi_edge_synchronizer_if.slave   bus
);

  logic [P_CH_NUM-1:0] w_level;
  logic [P_CH_NUM-1:0] w_pulse;
  logic [P_CH_NUM-1:0] w_ovf;

  for (genvar g = 0; g < P_CH_NUM; g++) begin : g_chan
    cbb_sync_chan #(
      .P_SYNC_STAGE (P_SYNC_STAGE),
      .P_FILT_LEN   (P_FILT_LEN),
      .P_STRETCH    (P_STRETCH)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_async    (bus.i_async[g]),
      .i_edge_sel (bus.i_edge_sel[2*g+1 : 2*g]),
      .i_en       (bus.i_en),
      .i_ovf_clr  (bus.i_ovf_clr),
      .o_level    (w_level[g]),
      .o_pulse    (w_pulse[g]),
      .o_ovf      (w_ovf[g])
    );
  end

  assign bus.o_level = w_level;
  assign bus.o_pulse = w_pulse;
  assign bus.o_ovf   = w_ovf;

endmodule

// File: doc/cbb_multi_edge_synchronizer.md
Name: cbb_multi_edge_synchronizer

Overview:
Multi-channel successor to the single-pulse synchronizer. Each of P_CH_NUM asynchronous inputs gets an N-stage synchronizer, a glitch filter and a run-time selectable edge/level detector. Each channel drives a stretched, retriggerable event pulse with a sticky overflow flag. The block sits at the boundary where external or foreign-domain event lines enter a single i_clk domain.

Parameters:
P_CH_NUM, 4, number of independent channels (1..32)
P_SYNC_STAGE, 2, synchronizer flops per channel (>=2)
P_FILT_LEN, 3, consecutive identical synchronized samples required to accept a level change (1..16; 1 = filter bypass)
P_STRETCH, 4, output event pulse width in i_clk cycles (1..255)

Ports:
i_clk  in  1  single clock; all logic in this domain
i_rst  in  1  asynchronous, active-high reset
i_async  in  P_CH_NUM  asynchronous event/level inputs
i_edge_sel  in  2*P_CH_NUM  per-channel mode, bits [2c+1:2c]: 00 rise, 01 fall, 10 both, 11 level
i_en  in  1  global event enable
i_ovf_clr  in  1  clears all o_ovf bits
o_level  out  P_CH_NUM  filtered, synchronized level
o_pulse  out  P_CH_NUM  stretched event pulse (or delayed level in mode 11)
o_ovf  out  P_CH_NUM  sticky: event arrived while pulse still stretching

Behaviour:
- Reset: all synchronizer flops, filter counters, o_level, o_pulse, stretch counters and o_ovf go to 0 immediately on i_rst.
- Synchronizer: s[0] <= i_async. s[k] <= s[k-1]. sync = s[P_SYNC_STAGE-1].
- Filter:
  - Per-channel counter of width clog2(P_FILT_LEN+1).
  - If sync == o_level: cnt <= 0.
  - Else if cnt == P_FILT_LEN-1: o_level <= sync, cnt <= 0.
  - Else: cnt++.
  - A change held stable through P_SYNC_STAGE+P_FILT_LEN sampling edges updates o_level at edge P_SYNC_STAGE+P_FILT_LEN, counting the first sampling edge as 1.
  - Shorter glitches are discarded.
- Edge detect: lvl_d <= o_level. rise = o_level & ~lvl_d. fall = ~o_level & lvl_d. evt is selected per i_edge_sel (both = rise|fall), gated by i_en.
- Stretch, modes 00/01/10:
  - On evt: o_pulse <= 1, scnt <= P_STRETCH-1.
  - Else if scnt != 0: scnt--, o_pulse holds 1.
  - Else: o_pulse <= 0.
  - o_pulse therefore rises one cycle after o_level changes and stays high for exactly P_STRETCH cycles.
- Retrigger: evt while o_pulse==1 and the pulse is not in its final cycle (scnt != 0) reloads scnt, so the pulse is extended. o_ovf[c] <= 1 in the same cycle.
- o_ovf:
  - i_ovf_clr clears all bits.
  - A set and a clear in the same cycle: the set wins.
- Mode 11: o_pulse <= o_level each cycle (1-cycle delay). No stretch, no ovf, i_en ignored.
- i_en low: no new events. Stretches in progress complete normally. Sync and filter keep running, so re-enabling never creates a false edge.
- i_edge_sel change: takes effect next cycle. An active stretch is not truncated. Switching from 11 to an edge mode forces o_pulse to follow the stretch logic from the next cycle (scnt = 0, so o_pulse drops unless an evt occurs).
- Reset release with input high: o_level rises after the filter latency and produces a normal rise event. This is intended.
- Channels are fully independent. Simultaneous events on several channels are all honoured.

Decomposition:
- Shared package/header cbb_sync_pkg: edge-mode encodings (EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_LEVEL=2'b11) and a clog2 function for counter widths.
- Sub-module cbb_sync_chan: one channel (sync, filter, edge, stretch, ovf).
- Top generates P_CH_NUM instances and slices i_edge_sel.

Test Plan:
Defaults throughout, i_en=1 unless stated.
1. ch0 mode 00; i_async[0] 0->1 held 10 cycles, first sampled at edge 1 -> o_level[0]=1 at edge 5; o_pulse[0]=1 edges 6..9, 0 at edge 10; o_ovf[0]=0.
2. ch1 mode 00; i_async[1] high for only 2 sampled cycles -> o_level[1] and o_pulse[1] never assert.
3. ch2 mode 10; high for 8 cycles then low -> two separate 4-cycle pulses, starting 8 cycles apart; o_ovf[2]=0.
4. ch3 mode 10; toggle every 3 cycles -> o_pulse[3] stays continuously high and o_ovf[3]=1; i_ovf_clr coinciding with a further event keeps o_ovf[3]=1; i_ovf_clr with no event clears it.
5. ch0 mode 00 with i_en=0, rising input -> o_level rises, no pulse. Switch to mode 11 -> o_pulse[0] equals o_level[0] delayed 1 cycle.
6. Assert i_rst mid-stretch (cycle 2 of 4) -> all outputs 0 immediately. Release with i_async[0]=1 -> o_level[0] at edge 5, 4-cycle pulse from edge 6.
